// File: rtl/cpu_pkg.sv
// Shared constants for the RV32 single-cycle datapath: opcode classes and ALU operation codes.
package cpu_pkg;

  localparam logic [6:0] OPC_R    = 7'h33;
  localparam logic [6:0] OPC_LW   = 7'h03;
  localparam logic [6:0] OPC_I    = 7'h13;
  localparam logic [6:0] OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_JAL  = 7'h6F;
  localparam logic [6:0] OPC_S    = 7'h23;
  localparam logic [6:0] OPC_SB   = 7'h63;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/exmem_alu.sv
// Execute-stage ALU: operand B mux, AND/OR/ADD/SUB (and signed SLT when ALU_SLT_EN is defined), zero detect.
module exmem_alu
  import cpu_pkg::*;
(
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] imm,
  input  logic [2:0]  alu_op,
  input  logic        alu_src,
  output logic [31:0] z,
  output logic        zero
);

  logic signed [31:0] op_a;
  logic signed [31:0] op_b;

  assign op_a = $signed(rd1);
  assign op_b = alu_src ? $signed(imm) : $signed(rd2);

  // Unlisted op codes resolve to 0 so a stray encoding reads as zero=1.
  always_comb begin
    z = 32'h0;
    case (alu_op)
      ALU_AND: z = op_a & op_b;
      ALU_OR:  z = op_a | op_b;
      ALU_ADD: z = op_a + op_b;
      ALU_SUB: z = op_a - op_b;
`ifdef ALU_SLT_EN
      ALU_SLT: z = {31'b0, op_a < op_b};
`endif
      default: z = 32'h0;
    endcase
  end

  assign zero = (z == 32'h0);

endmodule

// File: rtl/cpu_exmem_unit.sv
// Opcode class decoder, execute ALU and word-addressed data memory of the RV32 datapath.
// Build option: define ALU_SLT_EN to enable signed SLT on alu_op 3'b111.
module cpu_exmem_unit
  import cpu_pkg::*;
#(
  parameter int DM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] imm,
  input  logic [2:0]  alu_op,
  input  logic        alu_src,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] z,
  output logic        zero,
  output logic [31:0] mem_out,
  output logic        is_stype,
  output logic        is_rtype,
  output logic        is_itype,
  output logic        is_lw,
  output logic        is_jump,
  output logic        is_branch
);

  localparam int AW = $clog2(DM_DEPTH);

  logic [31:0]   mem [DM_DEPTH];
  logic [AW-1:0] idx;

  assign is_stype  = (opcode == OPC_S);
  assign is_rtype  = (opcode == OPC_R);
  assign is_itype  = (opcode == OPC_I) || (opcode == OPC_LW) || (opcode == OPC_JALR);
  assign is_lw     = (opcode == OPC_LW);
  assign is_jump   = (opcode == OPC_JAL);
  assign is_branch = (opcode == OPC_SB);

  exmem_alu u_alu (
    .rd1     (rd1),
    .rd2     (rd2),
    .imm     (imm),
    .alu_op  (alu_op),
    .alu_src (alu_src),
    .z       (z),
    .zero    (zero)
  );

  // Byte offset dropped, upper bits truncated: addresses alias modulo DM_DEPTH words.
  assign idx = AW'(z >> 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DM_DEPTH; i++) mem[i] <= 32'h0;
    end else if (mem_write) begin
      mem[idx] <= rd2;
    end
  end

  assign mem_out = mem_read ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_cpu_exmem_unit.sv
// Directed self-checking bench for cpu_exmem_unit: decode, ALU, store/load, address wrap and reset.
module tb_cpu_exmem_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [31:0] rd1, rd2, imm;
  logic [2:0]  alu_op;
  logic        alu_src, mem_read, mem_write;
  logic [31:0] z, mem_out;
  logic        zero;
  logic        is_stype, is_rtype, is_itype, is_lw, is_jump, is_branch;

  int total = 0;
  int bad   = 0;

  cpu_exmem_unit #(.DM_DEPTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .rd1       (rd1),
    .rd2       (rd2),
    .imm       (imm),
    .alu_op    (alu_op),
    .alu_src   (alu_src),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .z         (z),
    .zero      (zero),
    .mem_out   (mem_out),
    .is_stype  (is_stype),
    .is_rtype  (is_rtype),
    .is_itype  (is_itype),
    .is_lw     (is_lw),
    .is_jump   (is_jump),
    .is_branch (is_branch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {26'b0, is_stype, is_rtype, is_itype, is_lw, is_jump, is_branch};
  endfunction

  // Drive ALU to compute z = a + 0 so the memory address equals a.
  task automatic set_addr(input logic [31:0] a);
    rd1 = a; imm = 32'h0; alu_src = 1'b1; alu_op = ALU_ADD;
  endtask

  typedef struct { logic [6:0] opc; logic [5:0] exp; } dec_vec_t;
  dec_vec_t dec_tab[8] = '{
    '{7'h03, 6'b001100}, '{7'h33, 6'b010000}, '{7'h7F, 6'b000000},
    '{7'h13, 6'b001000}, '{7'h67, 6'b001000}, '{7'h6F, 6'b000010},
    '{7'h63, 6'b000001}, '{7'h23, 6'b100000}
  };

  typedef struct {
    logic [31:0] a, b; logic [2:0] op; logic [31:0] ez; logic ezero;
  } alu_vec_t;
  alu_vec_t alu_tab[7] = '{
    '{32'd5,        32'd7,        3'b010, 32'd12,       1'b0},
    '{32'd9,        32'd9,        3'b110, 32'd0,        1'b1},
    '{32'h0000F0F0, 32'h0000FF00, 3'b000, 32'h0000F000, 1'b0},
    '{32'h0000F0F0, 32'h0000FF00, 3'b001, 32'h0000FFF0, 1'b0},
    '{32'd5,        32'd7,        3'b110, 32'hFFFFFFFE, 1'b0},
    '{32'hFFFFFFFF, 32'd1,        3'b010, 32'h00000000, 1'b1},
    '{32'h12345678, 32'h1,        3'b011, 32'h00000000, 1'b1}
  };

  initial begin
    rst_n = 1'b0; opcode = 7'h0; rd1 = 0; rd2 = 0; imm = 0;
    alu_op = ALU_ADD; alu_src = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
    #1;
    chk("rst_mem_out", mem_out, 32'h0);
    chk("rst_flags", flags(), 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    mem_read = 1'b0;

    foreach (dec_tab[i]) begin
      opcode = dec_tab[i].opc; #1;
      chk($sformatf("dec_%02h", dec_tab[i].opc), flags(), {26'b0, dec_tab[i].exp});
    end

    foreach (alu_tab[i]) begin
      rd1 = alu_tab[i].a; rd2 = alu_tab[i].b; alu_op = alu_tab[i].op; alu_src = 1'b0; #1;
      chk($sformatf("alu_z_%0d", i), z, alu_tab[i].ez);
      chk($sformatf("alu_zero_%0d", i), {31'b0, zero}, {31'b0, alu_tab[i].ezero});
    end

    rd1 = 32'h28; rd2 = 32'h1000; imm = 32'hFFFFFFFC; alu_src = 1'b1; alu_op = ALU_ADD; #1;
    chk("alu_imm", z, 32'h24);

    rd1 = 32'hFFFFFFFF; rd2 = 32'd1; alu_src = 1'b0; alu_op = ALU_SLT; #1;
`ifdef ALU_SLT_EN
    chk("slt_neg", z, 32'd1);
    rd1 = 32'd1; rd2 = 32'hFFFFFFFF; #1;
    chk("slt_pos", z, 32'd0);
`else
    chk("op111_undef_z", z, 32'd0);
    chk("op111_undef_zero", {31'b0, zero}, 32'd1);
`endif

    // Store and load with read-during-write.
    @(negedge clk);
    set_addr(32'h10); rd2 = 32'hDEADBEEF; mem_write = 1'b1; mem_read = 1'b1; #1;
    chk("rdw_old", mem_out, 32'h0);
    @(posedge clk); #1;
    chk("rdw_new", mem_out, 32'hDEADBEEF);
    mem_write = 1'b0; #1;
    chk("load_w4", mem_out, 32'hDEADBEEF);
    mem_read = 1'b0; #1;
    chk("read_off", mem_out, 32'h0);

    // Misaligned, out-of-range address aliases onto word 0.
    @(negedge clk);
    set_addr(32'h103); rd2 = 32'hA5; mem_write = 1'b1;
    @(posedge clk); #1;
    mem_write = 1'b0; set_addr(32'h0); mem_read = 1'b1; #1;
    chk("wrap_w0", mem_out, 32'hA5);
    set_addr(32'h10); #1;
    chk("wrap_w4_kept", mem_out, 32'hDEADBEEF);

    // Async reset mid-cycle clears memory; a store during reset is lost.
    @(negedge clk); #2;
    rd2 = 32'h1234; mem_write = 1'b1;
    rst_n = 1'b0; #1;
    chk("rst_clr_w4", mem_out, 32'h0);
    @(posedge clk); #1;
    chk("rst_store_lost", mem_out, 32'h0);
    @(negedge clk);
    mem_write = 1'b0; rst_n = 1'b1; #1;
    chk("post_rst_w4", mem_out, 32'h0);
    set_addr(32'h0); #1;
    chk("post_rst_w0", mem_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
